// File: rtl/instr_prefetch_queue_pkg.sv
// instr_prefetch_queue_pkg: shared FSM state, widths and queue entry type for the prefetch queue
package instr_prefetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} ipq_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ipq_entry_t;
endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// ipq_fifo: DEPTH x 64-bit queue of {pc, inst} entries with flush
// Ports: clk_i/rst_i clock and sync reset; flush_i empties the queue and wins over push/pop;
//        push_i/din_i write tail; pop_i/dout_o read head; full_o, empty_o, count_o occupancy.
module ipq_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [2*XLEN-1:0]        din_i,
  input  logic                     pop_i,
  output logic [2*XLEN-1:0]        dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [2*XLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign empty_o = r_cnt == '0;
  assign full_o  = r_cnt == CW'(DEPTH);
  assign count_o = r_cnt;
  assign dout_o  = r_mem[r_rp];
  assign w_pop   = pop_i & !empty_o;
  // a push into a full queue is legal only when the head leaves in the same cycle
  assign w_push  = push_i & (!full_o | w_pop);
  always_ff @(posedge clk_i) begin
    if (rst_i | flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push & !flush_i) r_mem[r_wp] <= din_i;
  end
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: instruction fetch engine feeding decode through a small in-order queue
// Ports: clk_i/rst_i clock and sync active-high reset; start_i fetch enable;
//        imem_req_o/imem_addr_o/imem_rdy_i request channel; imem_rvalid_i/imem_rdata_i in-order responses;
//        redirect_i/redirect_pc_i flush and restart; inst_valid_o/inst_o/inst_pc_o/inst_ready_i decode side.
// Optional: define IPQ_BYPASS_EN to hand a response straight to decode when the queue is empty.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rdy_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  ipq_state_t r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_rpc, w_redir_pc;
  logic [CW-1:0] r_out, r_disc, w_cnt, w_disc_ld;
  logic [2*XLEN-1:0] w_dout;
  ipq_entry_t w_head, w_push_ent;
  logic w_accept, w_resp, w_push, w_pop, w_byp, w_empty, w_full, w_room;
  // responses with nothing outstanding belong to requests from before reset
  assign w_resp     = imem_rvalid_i & (r_out != '0);
  assign w_room     = !w_full & (({1'b0, w_cnt} + {1'b0, r_out}) < (CW + 1)'(DEPTH));
  // the response landing in the redirect cycle is already accounted for
  assign w_disc_ld  = r_out - CW'(w_resp);
  assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};
`ifdef IPQ_BYPASS_EN
  assign w_byp = w_resp & w_empty & inst_ready_i & !redirect_i & (r_state != ST_DRAIN);
`else
  assign w_byp = 1'b0;
`endif
  assign w_push       = w_resp & !redirect_i & (r_state != ST_DRAIN) & !w_byp;
  assign inst_valid_o = (!w_empty | w_byp) & (r_state != ST_DRAIN);
  assign w_pop        = inst_valid_o & inst_ready_i & !w_byp & !redirect_i;
  assign w_head       = w_dout;
  assign w_push_ent   = '{pc: r_rpc, inst: imem_rdata_i};
  assign inst_o       = !inst_valid_o ? '0 : w_byp ? imem_rdata_i : w_head.inst;
  assign inst_pc_o    = !inst_valid_o ? '0 : w_byp ? r_rpc : w_head.pc;
  assign imem_addr_o  = r_pc;
  assign w_accept     = imem_req_o & imem_rdy_i;
  always_comb begin
    w_state_nxt = r_state;
    imem_req_o  = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = start_i ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        imem_req_o  = start_i & w_room & !redirect_i;
        w_state_nxt = redirect_i ? ((w_disc_ld != '0) ? ST_DRAIN : ST_RUN)
                    : (!start_i && r_out == '0) ? ST_IDLE : ST_RUN;
      end
      ST_DRAIN: w_state_nxt = (w_resp && r_disc == CW'(1)) ? ST_RUN : ST_DRAIN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_rpc   <= RESET_PC;
      r_out   <= '0;
      r_disc  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= r_out + CW'(w_accept) - CW'(w_resp);
      if (redirect_i) begin
        r_pc   <= w_redir_pc;
        r_rpc  <= w_redir_pc;
        r_disc <= w_disc_ld;
      end else begin
        if (w_accept) r_pc <= r_pc + PC_STEP;
        if (w_push | w_byp) r_rpc <= r_rpc + PC_STEP;
        if (w_resp && r_state == ST_DRAIN) r_disc <= r_disc - CW'(1);
      end
    end
  end
  ipq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (w_push),
    .din_i   (w_push_ent),
    .pop_i   (w_pop),
    .dout_o  (w_dout),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_cnt)
  );
endmodule
